// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: synchronises the serial line, detects the start bit and samples
// each bit at mid-period using a runtime bit period latched at start detect.
module uart_rx #(
    parameter int unsigned DW          = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic [19:0]   baud,
    input  logic          rx_in,
    output logic [DW-1:0] dout,
    output logic          rx_valid,
    output logic          rx_err,
    output logic          rx_busy
);

    localparam int unsigned BW = 20;
    localparam int unsigned IW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [BW-1:0] BAUD_MIN = BW'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_p;
    logic                   w_rx_s;
    logic [BW-1:0]          r_cnt;
    logic [BW-1:0]          w_cnt_nxt;
    logic [BW-1:0]          r_baud;
    logic [BW-1:0]          w_baud_nxt;
    logic [IW-1:0]          r_idx;
    logic [IW-1:0]          w_idx_nxt;
    logic [DW-1:0]          r_sr;
    logic [DW-1:0]          w_sr_nxt;
    logic [DW-1:0]          r_dout;
    logic [DW-1:0]          w_dout_nxt;
    logic                   r_valid;
    logic                   w_valid_nxt;
    logic                   r_err;
    logic                   w_err_nxt;
    logic                   r_busy;
    logic                   w_busy_nxt;
    logic                   w_start;
    logic                   w_half;
    logic                   w_full;
    logic                   w_last;

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // Line synchroniser; resets to the idle (high) level so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= '1;
            r_rx_p <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_in};
            r_rx_p <= w_rx_s;
        end
    end

    assign w_start = sel & r_rx_p & ~w_rx_s & (baud >= BAUD_MIN);
    assign w_half  = (r_cnt == ((r_baud >> 1) - BW'(1)));
    assign w_full  = (r_cnt == (r_baud - BW'(1)));
    assign w_last  = (r_idx == IW'(DW - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!sel) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_start) w_state_nxt = S_START;
                S_START:   if (w_half) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                S_DATA:    if (w_full && w_last) w_state_nxt = S_STOP;
                S_STOP:    if (w_full) w_state_nxt = w_rx_s ? S_IDLE : S_WAIT_HI;
                S_WAIT_HI: if (w_rx_s) w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_cnt_nxt   = r_cnt + BW'(1);
        w_baud_nxt  = r_baud;
        w_idx_nxt   = r_idx;
        w_sr_nxt    = r_sr;
        w_dout_nxt  = r_dout;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_start) w_baud_nxt = baud;
            end
            S_START: begin
                if (w_half) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = '0;
                end
            end
            S_DATA: begin
                if (w_full) begin
                    w_cnt_nxt = '0;
                    w_sr_nxt  = {w_rx_s, r_sr[DW-1:1]};
                    w_idx_nxt = r_idx + IW'(1);
                end
            end
            S_STOP: begin
                if (w_full) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_dout_nxt  = r_sr;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            default: w_cnt_nxt = '0;
        endcase
        // Disabling the receiver abandons the frame without reporting anything
        if (!sel) begin
            w_cnt_nxt   = '0;
            w_dout_nxt  = r_dout;
            w_valid_nxt = 1'b0;
            w_err_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_baud  <= '0;
            r_idx   <= '0;
            r_sr    <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_baud  <= w_baud_nxt;
            r_idx   <= w_idx_nxt;
            r_sr    <= w_sr_nxt;
            r_dout  <= w_dout_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign dout     = r_dout;
    assign rx_valid = r_valid;
    assign rx_err   = r_err;
    assign rx_busy  = r_busy;

endmodule
